// File: rtl/sw_req_capture_pkg.sv
// Shared definitions for the switch/button request capture front-end.
// - DB_CYCLES_DEF : default debounce length (10 ms at 50 MHz)
// - MODE_LEVEL / MODE_STICKY : encodings of the 'mode' input
// - cnt_width()   : width of a counter that must reach cycles-1 without wrapping
package sw_req_capture_pkg;

    localparam int   DB_CYCLES_DEF = 500000;
    localparam logic MODE_LEVEL    = 1'b0;
    localparam logic MODE_STICKY   = 1'b1;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/sw_req_capture_debounce_bit.sv
// Single-bit synchroniser + debouncer.
// Ports:
//   clk    in   system clock, all state on posedge
//   rst    in   synchronous active-high reset
//   sw_in  in   raw asynchronous switch level
//   stable out  debounced level (registered)
//   rise   out  combinational 0->1 indication, high for the one cycle after
//               'stable' rises; the parent registers it and feeds its sticky latch
module debounce_bit
    import sw_req_capture_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic stable,
    output logic rise
);

    localparam int              CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    logic             stable_reg;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            s1_reg       <= sw_in;
            s2_reg       <= s1_reg;
            stable_d_reg <= stable_reg;
            // Any sample that agrees with the accepted level restarts the
            // count, so only an uninterrupted run of DB_CYCLES differing
            // samples is accepted. The counter is cleared on acceptance and
            // therefore never wraps.
            if (s2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                stable_reg <= s2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/sw_req_capture.sv
// Front-end that turns raw switch/button inputs into a clean request vector
// for the downstream priority encoder.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sw_in      in   [WIDTH] raw asynchronous switch levels
//   mode       in   0 = level (req = debounced level), 1 = sticky latch of presses
//   clr        in   one-cycle pulse clearing the sticky latch
//   req        out  [WIDTH] registered request vector
//   req_valid  out  |req
//   rise_pulse out  [WIDTH] one-cycle pulse per accepted 0->1 transition
module sw_req_capture
    import sw_req_capture_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             mode,
    input  logic             clr,
    output logic [WIDTH-1:0] req,
    output logic             req_valid,
    output logic [WIDTH-1:0] rise_pulse
);

    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] rise_now;
    logic [WIDTH-1:0] sticky_reg;
    logic [WIDTH-1:0] sticky_next;
    logic [WIDTH-1:0] req_reg;
    logic [WIDTH-1:0] rise_pulse_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
            debounce_bit #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .sw_in (sw_in[gi]),
                .stable(stable_vec[gi]),
                .rise  (rise_now[gi])
            );
        end
    endgenerate

    // A rise coinciding with clr survives the clear.
    always_comb begin
        sticky_next = (clr ? '0 : sticky_reg) | rise_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg     <= '0;
            req_reg        <= '0;
            rise_pulse_reg <= '0;
        end else begin
            // The latch keeps accumulating in level mode so a later switch
            // to sticky mode shows every press since the last clear.
            sticky_reg     <= sticky_next;
            rise_pulse_reg <= rise_now;
            req_reg        <= (mode == MODE_LEVEL) ? stable_vec : sticky_next;
        end
    end

    assign req        = req_reg;
    assign req_valid  = |req_reg;
    assign rise_pulse = rise_pulse_reg;

endmodule
